// File: rtl/dcache_mem_ctrl.sv
// ----------------------------------------------------------------------------
// dcache_mem_ctrl
//
// Miss and write-through controller between a direct-mapped data cache and
// a multi-cycle data memory.
//   - A read miss stalls the pipeline, waits for the posted write buffer to
//     drain, fetches the word from memory and returns it to the cache with a
//     one-cycle fill strobe.
//   - Every store is pushed into a small circular write buffer, whether or not
//     the cache hit, and is then written to memory in program order.
//   - The memory port has one owner per cycle. Buffered writes may use it in
//     IDLE/DRAIN, and the single outstanding read uses it only in RD_REQ.
//
// Ports
//   CLK, RST_N   clock, asynchronous active-low reset
//   MemRead      pipeline load request
//   MemWrite     pipeline store request (wins if MemRead is also set)
//   A, WD, BE    access byte address, store data, store byte enables
//   hit_i        cache hit flag
//   FoundData    fill word to the cache
//   FillValid    one-cycle fill strobe to the cache
//   Stall        freezes the pipeline (holds A/WD/BE/MemRead/MemWrite)
//   mem_req      memory request valid, held until mem_ready
//   mem_we       1 = write, 0 = read
//   mem_addr     memory request address
//   mem_wdata    memory write data
//   mem_be       memory write byte enables
//   mem_ready    memory accepts the request at this rising edge
//   mem_rvalid   read data valid (only observed in RD_WAIT)
//   mem_rdata    read data
// ----------------------------------------------------------------------------
module dcache_mem_ctrl #(
    parameter int unsigned ADDRESS_WIDTH = 17,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned WB_DEPTH      = 4
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [ADDRESS_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0]    WD,
    input  logic [3:0]               BE,
    input  logic                     hit_i,
    output logic [DATA_WIDTH-1:0]    FoundData,
    output logic                     FillValid,
    output logic                     Stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [3:0]               mem_be,
    input  logic                     mem_ready,
    input  logic                     mem_rvalid,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam int unsigned PtrWidth = $clog2(WB_DEPTH);
    localparam int unsigned CntWidth = PtrWidth + 1;
    localparam logic [CntWidth-1:0] WbFull = CntWidth'(WB_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StRdReq,
        StRdWait,
        StFill,
        StResume
    } state_e;

    state_e r_state;
    state_e w_state_next;

    // Write buffer storage and bookkeeping
    logic [ADDRESS_WIDTH-1:0] r_wb_addr [WB_DEPTH];
    logic [DATA_WIDTH-1:0]    r_wb_data [WB_DEPTH];
    logic [3:0]               r_wb_be   [WB_DEPTH];
    logic [PtrWidth-1:0]      r_wr_ptr;
    logic [PtrWidth-1:0]      r_rd_ptr;
    logic [CntWidth-1:0]      r_wb_count;

    logic [ADDRESS_WIDTH-1:0] r_miss_addr;
    logic [DATA_WIDTH-1:0]    r_fill_data;

    logic w_wb_empty;
    logic w_wb_full;
    logic w_miss;
    logic w_push;
    logic w_wr_owner;
    logic w_pop;
    logic w_latch_miss;
    logic w_capture;

    assign w_wb_empty = (r_wb_count == '0);
    assign w_wb_full  = (r_wb_count == WbFull);

    // A simultaneous load and store is treated as a store only.
    assign w_miss = MemRead & ~MemWrite & ~hit_i;

    // Stores are only accepted in IDLE; in every other state the pipeline is
    // frozen on the missing load, so no store can be presented.
    assign w_push = (r_state == StIdle) & MemWrite & ~w_wb_full;

    // The buffer owns the memory port in IDLE/DRAIN whenever it holds data.
    assign w_wr_owner = ((r_state == StIdle) | (r_state == StDrain)) & ~w_wb_empty;
    assign w_pop      = w_wr_owner & mem_ready;

    assign FoundData = r_fill_data;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        Stall        = 1'b0;
        FillValid    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_be       = '0;
        w_latch_miss = 1'b0;
        w_capture    = 1'b0;

        if (w_wr_owner) begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = r_wb_addr[r_rd_ptr];
            mem_wdata = r_wb_data[r_rd_ptr];
            mem_be    = r_wb_be[r_rd_ptr];
        end

        unique case (r_state)
            StIdle: begin
                if (w_miss) begin
                    Stall        = 1'b1;
                    w_latch_miss = 1'b1;
                    // Reads may not overtake buffered writes.
                    w_state_next = w_wb_empty ? StRdReq : StDrain;
                end else if (MemWrite && w_wb_full) begin
                    // Store is held by the pipeline until a slot frees up.
                    Stall = 1'b1;
                end
            end

            StDrain: begin
                Stall = 1'b1;
                if (w_wb_empty) begin
                    w_state_next = StRdReq;
                end
            end

            StRdReq: begin
                Stall    = 1'b1;
                mem_req  = 1'b1;
                mem_we   = 1'b0;
                mem_addr = r_miss_addr;
                if (mem_ready) begin
                    w_state_next = StRdWait;
                end
            end

            StRdWait: begin
                Stall = 1'b1;
                if (mem_rvalid) begin
                    w_capture    = 1'b1;
                    w_state_next = StFill;
                end
            end

            StFill: begin
                Stall        = 1'b1;
                FillValid    = 1'b1;
                w_state_next = StResume;
            end

            StResume: begin
                // One extra cycle lets the cache's registered hit flag settle.
                Stall        = 1'b1;
                w_state_next = StIdle;
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Miss address and fill data
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_miss_addr <= '0;
            r_fill_data <= '0;
        end else begin
            if (w_latch_miss) begin
                r_miss_addr <= A;
            end
            if (w_capture) begin
                r_fill_data <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Write buffer: circular FIFO, pointers wrap naturally (power-of-two depth)
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wb_count <= '0;
            for (int unsigned i = 0; i < WB_DEPTH; i++) begin
                r_wb_addr[i] <= '0;
                r_wb_data[i] <= '0;
                r_wb_be[i]   <= '0;
            end
        end else begin
            if (w_push) begin
                r_wb_addr[r_wr_ptr] <= A;
                r_wb_data[r_wr_ptr] <= WD;
                r_wb_be[r_wr_ptr]   <= BE;
                r_wr_ptr            <= r_wr_ptr + PtrWidth'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_wb_count <= r_wb_count + CntWidth'(1);
                2'b01:   r_wb_count <= r_wb_count - CntWidth'(1);
                default: r_wb_count <= r_wb_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
module tb_dcache_mem_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        MemRead;
    logic        MemWrite;
    logic [16:0] A;
    logic [31:0] WD;
    logic [3:0]  BE;
    logic        hit_i;
    logic [31:0] FoundData;
    logic        FillValid;
    logic        Stall;
    logic        mem_req;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    dcache_mem_ctrl #(
        .ADDRESS_WIDTH(17),
        .DATA_WIDTH   (32),
        .WB_DEPTH     (4)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .A         (A),
        .WD        (WD),
        .BE        (BE),
        .hit_i     (hit_i),
        .FoundData (FoundData),
        .FillValid (FillValid),
        .Stall     (Stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_ready (mem_ready),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        we;
        logic [16:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } req_t;

    req_t log_q[$];
    int   fill_cnt = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Accepted memory requests and fill strobes, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            if (mem_req === 1'b1 && mem_ready === 1'b1) begin
                log_q.push_back('{mem_we, mem_addr, mem_wdata, mem_be});
            end
            if (FillValid === 1'b1) begin
                fill_cnt++;
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_entry(input string tag, input int idx, input logic we,
                               input logic [16:0] addr, input logic [31:0] data,
                               input logic [3:0] be);
        if (idx < log_q.size()) begin
            check_val({tag, "_we"},   64'(log_q[idx].we),   64'(we));
            check_val({tag, "_addr"}, 64'(log_q[idx].addr), 64'(addr));
            check_val({tag, "_data"}, 64'(log_q[idx].data), 64'(data));
            check_val({tag, "_be"},   64'(log_q[idx].be),   64'(be));
        end else begin
            check_val({tag, "_present"}, 64'(0), 64'(1));
        end
    endtask

    logic [16:0] exp_a  [10];
    logic [31:0] exp_d  [10];
    logic [3:0]  exp_be [10];
    logic        pend;
    logic        done;
    logic        saw_fill;
    logic [31:0] fill_word;

    initial begin
        RST_N      = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        A          = '0;
        WD         = '0;
        BE         = '0;
        hit_i      = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        cyc();
        cyc();
        #1;
        check_val("rst_stall",     64'(Stall),     64'(0));
        check_val("rst_fillvalid", 64'(FillValid), 64'(0));
        check_val("rst_founddata", 64'(FoundData), 64'(0));
        check_val("rst_mem_req",   64'(mem_req),   64'(0));
        check_val("rst_mem_we",    64'(mem_we),    64'(0));
        check_val("rst_mem_addr",  64'(mem_addr),  64'(0));
        check_val("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check_val("rst_mem_be",    64'(mem_be),    64'(0));
        cyc();
        RST_N = 1'b1;
        cyc();

        // ---- Reset in the middle of RD_WAIT, then a late rvalid ----
        MemRead   = 1'b1;
        hit_i     = 1'b0;
        A         = 17'h00ABC;
        mem_ready = 1'b1;
        cyc();                          // RD_REQ
        cyc();                          // RD_WAIT
        #1;
        check_val("midrst_wait_stall", 64'(Stall), 64'(1));
        RST_N   = 1'b0;
        MemRead = 1'b0;
        #1;
        check_val("midrst_stall",   64'(Stall),   64'(0));
        check_val("midrst_mem_req", 64'(mem_req), 64'(0));
        cyc();
        RST_N = 1'b1;
        cyc();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_BEEF;
        #1;
        check_val("late_rvalid_stall", 64'(Stall), 64'(0));
        cyc();
        mem_rvalid = 1'b0;
        #1;
        check_val("late_rvalid_founddata", 64'(FoundData), 64'(0));
        check_val("late_rvalid_fillvalid", 64'(FillValid), 64'(0));
        check_val("late_rvalid_fills",     64'(fill_cnt),  64'(0));
        cyc();

        // ---- Clean miss, minimum latency ----
        log_q.delete();
        MemRead   = 1'b1;
        hit_i     = 1'b0;
        A         = 17'h00104;
        mem_ready = 1'b1;
        #1;
        check_val("miss_c0_stall",   64'(Stall),   64'(1));
        check_val("miss_c0_mem_req", 64'(mem_req), 64'(0));
        cyc();
        #1;
        check_val("miss_c1_stall",    64'(Stall),    64'(1));
        check_val("miss_c1_mem_req",  64'(mem_req),  64'(1));
        check_val("miss_c1_mem_we",   64'(mem_we),   64'(0));
        check_val("miss_c1_mem_addr", 64'(mem_addr), 64'(17'h00104));
        cyc();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        #1;
        check_val("miss_c2_stall",     64'(Stall),     64'(1));
        check_val("miss_c2_fillvalid", 64'(FillValid), 64'(0));
        cyc();
        mem_rvalid = 1'b0;
        #1;
        check_val("miss_c3_stall",     64'(Stall),     64'(1));
        check_val("miss_c3_fillvalid", 64'(FillValid), 64'(1));
        check_val("miss_c3_founddata", 64'(FoundData), 64'(32'h1234_5678));
        cyc();
        #1;
        check_val("miss_c4_stall",     64'(Stall),     64'(1));
        check_val("miss_c4_fillvalid", 64'(FillValid), 64'(0));
        cyc();
        hit_i = 1'b1;
        #1;
        check_val("miss_c5_stall", 64'(Stall), 64'(0));
        cyc();
        MemRead = 1'b0;
        hit_i   = 1'b0;
        cyc();
        check_val("miss_fills",    64'(fill_cnt),     64'(1));
        check_val("miss_requests", 64'(log_q.size()), 64'(1));

        // ---- Buffer full with mem_ready low ----
        log_q.delete();
        mem_ready = 1'b0;
        exp_a[0] = 17'h00300; exp_d[0] = 32'hA000_0000; exp_be[0] = 4'hF;
        exp_a[1] = 17'h00304; exp_d[1] = 32'hA000_0001; exp_be[1] = 4'h1;
        exp_a[2] = 17'h00308; exp_d[2] = 32'hA000_0002; exp_be[2] = 4'h3;
        exp_a[3] = 17'h0030C; exp_d[3] = 32'hA000_0003; exp_be[3] = 4'hC;
        exp_a[4] = 17'h00310; exp_d[4] = 32'hA000_0004; exp_be[4] = 4'h8;
        for (int k = 0; k < 4; k++) begin
            MemWrite = 1'b1;
            A        = exp_a[k];
            WD       = exp_d[k];
            BE       = exp_be[k];
            #1;
            check_val($sformatf("full_push%0d_stall", k), 64'(Stall), 64'(0));
            cyc();
        end
        A  = exp_a[4];
        WD = exp_d[4];
        BE = exp_be[4];
        #1;
        check_val("full_5th_stall",    64'(Stall),    64'(1));
        check_val("full_head_req",     64'(mem_req),  64'(1));
        check_val("full_head_we",      64'(mem_we),   64'(1));
        check_val("full_head_addr",    64'(mem_addr), 64'(17'h00300));
        cyc();
        #1;
        check_val("full_hold_stall", 64'(Stall), 64'(1));
        mem_ready = 1'b1;
        #1;
        check_val("full_pop_stall", 64'(Stall), 64'(1));
        cyc();
        mem_ready = 1'b0;
        #1;
        check_val("full_release_stall", 64'(Stall), 64'(0));
        cyc();
        MemWrite  = 1'b0;
        mem_ready = 1'b1;
        done      = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc();
            #1;
            if (mem_req === 1'b0) done = 1'b1;
        end
        check_val("full_drain_done", 64'(done),         64'(1));
        check_val("full_wr_count",   64'(log_q.size()), 64'(5));
        for (int k = 0; k < 5; k++) begin
            check_entry($sformatf("full_wr%0d", k), k, 1'b1, exp_a[k], exp_d[k], exp_be[k]);
        end

        // ---- Ordering: two stores then a read miss ----
        log_q.delete();
        mem_ready = 1'b1;
        MemWrite  = 1'b1;
        A         = 17'h00200;
        WD        = 32'h1111_1111;
        BE        = 4'hF;
        cyc();
        A  = 17'h00204;
        WD = 32'h2222_2222;
        BE = 4'h3;
        cyc();
        MemWrite  = 1'b0;
        MemRead   = 1'b1;
        hit_i     = 1'b0;
        A         = 17'h00200;
        pend      = 1'b0;
        done      = 1'b0;
        saw_fill  = 1'b0;
        fill_word = '0;
        for (int i = 0; i < 30 && !done; i++) begin
            mem_rvalid = pend;
            mem_rdata  = 32'h0BAD_F00D;
            pend       = 1'b0;
            #1;
            if (FillValid === 1'b1) begin
                saw_fill  = 1'b1;
                fill_word = FoundData;
                hit_i     = 1'b1;
            end
            if (mem_req === 1'b1 && mem_we === 1'b0) pend = 1'b1;
            if (Stall === 1'b0) done = 1'b1;
            cyc();
        end
        MemRead    = 1'b0;
        hit_i      = 1'b0;
        mem_rvalid = 1'b0;
        check_val("order_done",      64'(done),         64'(1));
        check_val("order_fill_seen", 64'(saw_fill),     64'(1));
        check_val("order_fill_word", 64'(fill_word),    64'(32'h0BAD_F00D));
        check_val("order_req_count", 64'(log_q.size()), 64'(3));
        check_entry("order_wr0", 0, 1'b1, 17'h00200, 32'h1111_1111, 4'hF);
        check_entry("order_wr1", 1, 1'b1, 17'h00204, 32'h2222_2222, 4'h3);
        if (log_q.size() > 2) begin
            check_val("order_rd_we",   64'(log_q[2].we),   64'(0));
            check_val("order_rd_addr", 64'(log_q[2].addr), 64'(17'h00200));
        end else begin
            check_val("order_rd_present", 64'(0), 64'(1));
        end
        cyc();

        // ---- Wrap-around: 10 back-to-back stores with mem_ready high ----
        log_q.delete();
        mem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_a[i]  = 17'h00400 + 17'(4 * i);
            exp_d[i]  = 32'hC0DE_0000 + 32'(i);
            exp_be[i] = 4'(i + 1);
            MemWrite  = 1'b1;
            A         = exp_a[i];
            WD        = exp_d[i];
            BE        = exp_be[i];
            #1;
            check_val($sformatf("wrap%0d_stall", i), 64'(Stall), 64'(0));
            cyc();
        end
        MemWrite = 1'b0;
        #1;
        check_val("wrap_last_pending", 64'(mem_req), 64'(1));
        cyc();
        #1;
        check_val("wrap_empty",    64'(mem_req),      64'(0));
        check_val("wrap_wr_count", 64'(log_q.size()), 64'(10));
        for (int i = 0; i < 10; i++) begin
            check_entry($sformatf("wrap_wr%0d", i), i, 1'b1, exp_a[i], exp_d[i], exp_be[i]);
        end

        // ---- MemRead and MemWrite together: store only ----
        log_q.delete();
        MemRead  = 1'b1;
        MemWrite = 1'b1;
        hit_i    = 1'b0;
        A        = 17'h00500;
        WD       = 32'h5555_AAAA;
        BE       = 4'h9;
        #1;
        check_val("rw_stall", 64'(Stall), 64'(0));
        cyc();
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        #1;
        check_val("rw_mem_req",  64'(mem_req),  64'(1));
        check_val("rw_mem_we",   64'(mem_we),   64'(1));
        check_val("rw_mem_addr", 64'(mem_addr), 64'(17'h00500));
        for (int i = 0; i < 4; i++) cyc();
        check_val("rw_req_count", 64'(log_q.size()), 64'(1));
        check_entry("rw_wr", 0, 1'b1, 17'h00500, 32'h5555_AAAA, 4'h9);
        check_val("final_fills", 64'(fill_cnt), 64'(2));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
